f2i_ieee754_seq: RTL and testbench



---
 rtl/fp_ieee754_pkg.sv | 36 +++
 rtl/f2i_unpack.sv | 64 ++++++
 rtl/f2i_ieee754_seq.sv | 219 +++++++++++++++++++++
 tb/tb_f2i_ieee754_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_ieee754_pkg.sv
// ---------------------------------------------------------------------------
// fp_ieee754_pkg
// Shared IEEE-754 single-precision definitions for the float datapath
// (fadd_ieee754 and f2i_ieee754_seq).
//   - Field widths, exponent bias and the all-ones exponent code.
//   - Converter FSM state encoding.
//   - Field-slice helpers for sign, biased exponent and fraction.
// No ports (package).
// ---------------------------------------------------------------------------
package fp_ieee754_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic fp_sign(input logic [31:0] f);
      return f[31];
   endfunction

   function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] f);
      return f[30:23];
   endfunction

   function automatic logic [FRAC_W-1:0] fp_frac(input logic [31:0] f);
      return f[22:0];
   endfunction

endpackage

// File: rtl/f2i_unpack.sv
// ---------------------------------------------------------------------------
// f2i_unpack
// Combinational decode and classification of a single-precision operand for
// the float-to-int converter.
// Ports:
//   a          in   32  IEEE-754 single operand
//   sign       out  1   operand sign
//   mant       out  24  {1,frac}, or 0 when the exponent field is 0
//   e          out  10  unbiased exponent (signed)
//   is_zero    out  1   exponent field 0 (zero and flushed denormals)
//   is_nan_inf out  1   exponent field all ones
//   is_ovf     out  1   finite and e >= OUT_WIDTH-1
//   is_small   out  1   nonzero and e < 0 (magnitude below one)
//   shift_left out  1   e >= 23: mantissa moves left, else right
//   cnt        out  5   number of single-bit shifts, 0 for bypass cases
// ---------------------------------------------------------------------------
module f2i_unpack
   import fp_ieee754_pkg::*;
#(
   parameter int OUT_WIDTH = 32
) (
   input  logic [31:0]       a,
   output logic              sign,
   output logic [FRAC_W:0]   mant,
   output logic signed [9:0] e,
   output logic              is_zero,
   output logic              is_nan_inf,
   output logic              is_ovf,
   output logic              is_small,
   output logic              shift_left,
   output logic [4:0]        cnt
);

   localparam logic signed [9:0] E_OVF   = 10'(OUT_WIDTH - 1);
   localparam logic signed [9:0] E_POINT = 10'sd23;

   logic [EXP_W-1:0]  exp_s;
   logic [FRAC_W-1:0] frac_s;
   logic              bypass_s;

   // Field extraction, classification and shift distance
   always_comb begin
      exp_s      = fp_exp(a);
      frac_s     = fp_frac(a);
      sign       = fp_sign(a);
      e          = $signed({2'b00, exp_s}) - $signed(10'(BIAS));
      is_zero    = (exp_s == 8'd0);
      is_nan_inf = (exp_s == 8'(EXP_MAX));
      is_ovf     = !is_zero && !is_nan_inf && (e >= E_OVF);
      is_small   = !is_zero && (e < 10'sd0);
      // Denormals flush to zero exactly like the adder does
      mant       = is_zero ? 24'd0 : {1'b1, frac_s};
      shift_left = (e >= E_POINT);
      bypass_s   = is_zero || is_nan_inf || is_ovf || is_small;
      if (bypass_s) begin
         cnt = 5'd0;
      end else if (shift_left) begin
         cnt = 5'(e - E_POINT);
      end else begin
         cnt = 5'(E_POINT - e);
      end
   end

endmodule

// File: rtl/f2i_ieee754_seq.sv
// ---------------------------------------------------------------------------
// f2i_ieee754_seq
// Multi-cycle IEEE-754 single to signed OUT_WIDTH-bit integer converter.
// The mantissa is moved one bit per clock; latency from accept to out_valid
// is cnt+2 cycles (2 for zero, NaN/inf, overflow and |x|<1).
// Optional feature macro: ROUND_NEAREST_EN (round-to-nearest-even; when
// undefined the result truncates toward zero).
// Ports:
//   clk          in   1          rising-edge clock
//   rst          in   1          synchronous active-high reset
//   in_valid     in   1          in_a is valid
//   in_ready     out  1          converter can accept an operand (IDLE only)
//   in_a         in   32         IEEE-754 single operand
//   out_valid    out  1          result valid, held until out_ready
//   out_ready    in   1          consumer accepts the result
//   out_int      out  OUT_WIDTH  signed integer result
//   out_inexact  out  1          nonzero fraction bits were discarded
//   out_invalid  out  1          NaN, infinity or out of range; saturated
// ---------------------------------------------------------------------------
module f2i_ieee754_seq
   import fp_ieee754_pkg::*;
#(
   parameter int OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_a,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_int,
   output logic                 out_inexact,
   output logic                 out_invalid
);

   localparam int W = OUT_WIDTH;
   localparam logic [W:0]   MAG_MAX = {2'b00, {(W-1){1'b1}}};
   localparam logic [W:0]   MAG_MIN = {2'b01, {(W-1){1'b0}}};
   localparam logic [W-1:0] INT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [9:0] E_MIN_EXACT = 10'(W - 1);
   localparam logic signed [9:0] E_HALF      = -10'sd1;

   // Decoded operand
   logic              u_sign;
   logic [FRAC_W:0]   u_mant;
   logic signed [9:0] u_e;
   logic              u_zero;
   logic              u_nan_inf;
   logic              u_ovf;
   logic              u_small;
   logic              u_left;
   logic [4:0]        u_cnt;

   // Per-operation state
   state_t     state_r;
   logic [4:0] cnt_r;
   logic [W:0] work_r;
   logic       guard_r;
   logic       sticky_r;
   logic       sign_r;
   logic       nan_inf_r;
   logic       ovf_r;
   logic       min_exact_r;
   logic       left_r;

   // Finish-stage combinational results
   logic         round_inc_s;
   logic [W:0]   mag_s;
   logic [W-1:0] neg_s;
   logic         range_ovf_s;
   logic [W-1:0] fin_int_s;
   logic         fin_inexact_s;
   logic         fin_invalid_s;

   f2i_unpack #(
      .OUT_WIDTH (OUT_WIDTH)
   ) u_unpack (
      .a          (in_a),
      .sign       (u_sign),
      .mant       (u_mant),
      .e          (u_e),
      .is_zero    (u_zero),
      .is_nan_inf (u_nan_inf),
      .is_ovf     (u_ovf),
      .is_small   (u_small),
      .shift_left (u_left),
      .cnt        (u_cnt)
   );

   // Rounding increment, sign application and range saturation
   always_comb begin
`ifdef ROUND_NEAREST_EN
      // Nearest-even: round up above half, or at half when the lsb is odd
      round_inc_s = guard_r & (sticky_r | work_r[0]);
`else
      round_inc_s = 1'b0;
`endif
      mag_s         = work_r + {{W{1'b0}}, round_inc_s};
      neg_s         = ~mag_s[W-1:0] + {{(W-1){1'b0}}, 1'b1};
      // A negative result may reach 2^(W-1) in magnitude, a positive one may not
      range_ovf_s   = sign_r ? (mag_s > MAG_MIN) : (mag_s > MAG_MAX);
      fin_int_s     = '0;
      fin_inexact_s = 1'b0;
      fin_invalid_s = 1'b0;
      if (nan_inf_r) begin
         fin_int_s     = INT_MAX;
         fin_invalid_s = 1'b1;
      end else if (ovf_r) begin
         if (min_exact_r) begin
            fin_int_s = INT_MIN;
         end else begin
            fin_int_s     = sign_r ? INT_MIN : INT_MAX;
            fin_invalid_s = 1'b1;
         end
      end else if (range_ovf_s) begin
         fin_int_s     = sign_r ? INT_MIN : INT_MAX;
         fin_invalid_s = 1'b1;
         fin_inexact_s = guard_r | sticky_r;
      end else begin
         fin_int_s     = sign_r ? neg_s : mag_s[W-1:0];
         fin_inexact_s = guard_r | sticky_r;
      end
   end

   // Converter FSM with shift datapath and registered handshake/result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_int     <= '0;
         out_inexact <= 1'b0;
         out_invalid <= 1'b0;
         cnt_r       <= 5'd0;
         work_r      <= '0;
         guard_r     <= 1'b0;
         sticky_r    <= 1'b0;
         sign_r      <= 1'b0;
         nan_inf_r   <= 1'b0;
         ovf_r       <= 1'b0;
         min_exact_r <= 1'b0;
         left_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  sign_r      <= u_sign;
                  nan_inf_r   <= u_nan_inf;
                  ovf_r       <= u_ovf;
                  // Exactly -2^(W-1) is representable despite e == W-1
                  min_exact_r <= u_ovf && u_sign && (u_e == E_MIN_EXACT) &&
                                 (u_mant[FRAC_W-1:0] == 23'd0);
                  left_r      <= u_left;
                  cnt_r       <= u_cnt;
                  if (u_small) begin
                     // |x| < 1: the leading one is the guard only when e == -1
                     work_r   <= '0;
                     guard_r  <= (u_e == E_HALF);
                     sticky_r <= (u_e != E_HALF) || (u_mant[FRAC_W-1:0] != 23'd0);
                  end else if (u_ovf || u_nan_inf || u_zero) begin
                     work_r   <= '0;
                     guard_r  <= 1'b0;
                     sticky_r <= 1'b0;
                  end else begin
                     work_r   <= {{(W-23){1'b0}}, u_mant};
                     guard_r  <= 1'b0;
                     sticky_r <= 1'b0;
                  end
                  in_ready <= 1'b0;
                  state_r  <= SHIFT;
               end else begin
                  in_ready <= 1'b1;
                  state_r  <= IDLE;
               end
            end
            SHIFT: begin
               if (cnt_r == 5'd0) begin
                  state_r <= FIN;
               end else begin
                  cnt_r <= cnt_r - 5'd1;
                  if (left_r) begin
                     work_r <= {work_r[W-1:0], 1'b0};
                  end else begin
                     // Previous guard retires into sticky; new guard is the bit leaving
                     work_r   <= {1'b0, work_r[W:1]};
                     guard_r  <= work_r[0];
                     sticky_r <= sticky_r | guard_r;
                  end
                  state_r <= SHIFT;
               end
            end
            FIN: begin
               out_int     <= fin_int_s;
               out_inexact <= fin_inexact_s;
               out_invalid <= fin_invalid_s;
               out_valid   <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r   <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_f2i_ieee754_seq.sv
// ---------------------------------------------------------------------------
// tb_f2i_ieee754_seq
// Self-checking bench for f2i_ieee754_seq (default OUT_WIDTH=32): directed
// vector table, hold/reset sequences and random operands compared against an
// arithmetic reference model. Honours ROUND_NEAREST_EN like the design.
// ---------------------------------------------------------------------------
module tb_f2i_ieee754_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_a;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_int;
   logic         out_inexact;
   logic         out_invalid;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] r;
      logic        ix;
      logic        iv;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   f2i_ieee754_seq #(.OUT_WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_int     (out_int),
      .out_inexact (out_inexact),
      .out_invalid (out_invalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: exact value mant*2^(e-23) split into integer part and remainder
   function automatic void model(input logic [31:0] a, output logic [W-1:0] r,
                                 output logic ix, output logic iv, output int lat);
      int ex, e;
      longint mant, mag, rem, half, v, maxv, minv;
      logic s;
      maxv = (64'sd1 <<< (W-1)) - 64'sd1;
      minv = -(64'sd1 <<< (W-1));
      s    = a[31];
      ex   = int'(a[30:23]);
      e    = ex - 127;
      mant = longint'({1'b1, a[22:0]});
      r = '0; ix = 1'b0; iv = 1'b0; lat = 2;
      if (ex == 255) begin
         r = maxv[W-1:0]; iv = 1'b1;
      end else if (ex == 0) begin
         r = '0;
      end else if (e >= W-1) begin
         if (s && a[22:0] == 23'd0 && e == W-1) r = minv[W-1:0];
         else begin r = s ? minv[W-1:0] : maxv[W-1:0]; iv = 1'b1; end
      end else begin
         if (e < -1) begin
            mag = 0; rem = 1; half = 2;
         end else if (e >= 23) begin
            mag = mant << (e - 23); rem = 0; half = 1; lat = e - 21;
         end else begin
            mag  = mant >> (23 - e);
            rem  = mant & ((64'sd1 << (23 - e)) - 64'sd1);
            half = 64'sd1 << (22 - e);
            if (e >= 0) lat = 25 - e;
         end
         ix = (rem != 0);
`ifdef ROUND_NEAREST_EN
         if (rem > half || (rem == half && mag[0])) mag = mag + 1;
`else
         if (half < 0) ix = 1'b1;
`endif
         v = s ? -mag : mag;
         if (v > maxv || v < minv) begin
            r = s ? minv[W-1:0] : maxv[W-1:0]; iv = 1'b1;
         end else begin
            r = v[W-1:0];
         end
      end
   endfunction

   // Present one operand and wait (bounded) for its result; does not consume it
   task automatic run_op(input logic [31:0] a, output logic [W-1:0] r,
                         output logic ix, output logic iv, output int lat);
      int waitc = 0;
      @(negedge clk);
      while (!in_ready && waitc < 100) begin @(negedge clk); waitc++; end
      if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      in_a = a; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
      r = out_int; ix = out_inexact; iv = out_invalid;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] r, er;
      logic ix, iv, eix, eiv;
      int lat, elat;
      logic [31:0] a;
      logic seen;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_int", 64'(out_int), 64'd0);
      chk("rst_inexact", 64'(out_inexact), 64'd0);
      chk("rst_invalid", 64'(out_invalid), 64'd0);
      rst = 1'b0;

      vecs.push_back('{32'h3F800000, 32'd1,          1'b0, 1'b0, 25});
      vecs.push_back('{32'hC0490FDB, 32'hFFFFFFFD,   1'b1, 1'b0, 24});
      vecs.push_back('{32'h4B000001, 32'd8388609,    1'b0, 1'b0, 2});
      vecs.push_back('{32'h4F000000, 32'h7FFFFFFF,   1'b0, 1'b1, 2});
      vecs.push_back('{32'hCF000000, 32'h80000000,   1'b0, 1'b0, 2});
      vecs.push_back('{32'h7FC00000, 32'h7FFFFFFF,   1'b0, 1'b1, 2});
      vecs.push_back('{32'hFF800000, 32'h7FFFFFFF,   1'b0, 1'b1, 2});
      vecs.push_back('{32'hCF000001, 32'h80000000,   1'b0, 1'b1, 2});
      vecs.push_back('{32'h3F000000, 32'd0,          1'b1, 1'b0, 2});
      vecs.push_back('{32'h00000001, 32'd0,          1'b0, 1'b0, 2});
      vecs.push_back('{32'h80000000, 32'd0,          1'b0, 1'b0, 2});
      vecs.push_back('{32'h4EFFFFFF, 32'h7FFFFF80,   1'b0, 1'b0, 9});
`ifdef ROUND_NEAREST_EN
      vecs.push_back('{32'h40200000, 32'd2,          1'b1, 1'b0, 24});
      vecs.push_back('{32'h40600000, 32'd4,          1'b1, 1'b0, 24});
      vecs.push_back('{32'hC0200000, 32'hFFFFFFFE,   1'b1, 1'b0, 24});
      vecs.push_back('{32'h3F400000, 32'd1,          1'b1, 1'b0, 2});
      vecs.push_back('{32'hBF400000, 32'hFFFFFFFF,   1'b1, 1'b0, 2});
`else
      vecs.push_back('{32'h40200000, 32'd2,          1'b1, 1'b0, 24});
      vecs.push_back('{32'h40600000, 32'd3,          1'b1, 1'b0, 24});
      vecs.push_back('{32'hC0200000, 32'hFFFFFFFE,   1'b1, 1'b0, 24});
      vecs.push_back('{32'h3F400000, 32'd0,          1'b1, 1'b0, 2});
      vecs.push_back('{32'hBF400000, 32'd0,          1'b1, 1'b0, 2});
`endif

      foreach (vecs[i]) begin
         run_op(vecs[i].a, r, ix, iv, lat);
         chk($sformatf("vec%0d_%h_int", i, vecs[i].a), 64'(r), 64'(vecs[i].r));
         chk($sformatf("vec%0d_%h_inexact", i, vecs[i].a), 64'(ix), 64'(vecs[i].ix));
         chk($sformatf("vec%0d_%h_invalid", i, vecs[i].a), 64'(iv), 64'(vecs[i].iv));
         chk($sformatf("vec%0d_%h_latency", i, vecs[i].a), 64'(lat), 64'(vecs[i].lat));
         consume();
      end

      // Result held in DONE while the consumer stalls
      run_op(32'hC0490FDB, r, ix, iv, lat);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d_int", k), 64'(out_int), 64'hFFFFFFFD);
         chk($sformatf("hold%0d_inexact", k), 64'(out_inexact), 64'd1);
         chk($sformatf("hold%0d_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
      end
      consume();
      chk("after_consume_valid", 64'(out_valid), 64'd0);
      chk("after_consume_in_ready", 64'(in_ready), 64'd1);

      // Reset in the middle of a long shift discards the operand
      @(negedge clk);
      in_a = 32'h3F800000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      chk("midrst_no_valid", 64'(seen), 64'd0);
      run_op(32'h3F800000, r, ix, iv, lat);
      chk("postrst_int", 64'(r), 64'd1);
      chk("postrst_latency", 64'(lat), 64'd25);
      consume();

      // Random operands, mostly with exponents near the integer range
      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[30:23] = 8'($urandom_range(118, 162));
         model(a, er, eix, eiv, elat);
         run_op(a, r, ix, iv, lat);
         chk($sformatf("rnd_%h_int", a), 64'(r), 64'(er));
         chk($sformatf("rnd_%h_inexact", a), 64'(ix), 64'(eix));
         chk($sformatf("rnd_%h_invalid", a), 64'(iv), 64'(eiv));
         chk($sformatf("rnd_%h_latency", a), 64'(lat), 64'(elat));
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
         consume();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
